// File: rtl/spatial_sram_sequencer.sv
// Sequences the nine item/projection SRAM banks of the three-modality spatial
// encoder, one channel at a time, and strobes per-modality accumulation.
//
// state | meaning
// IDLE  | waiting for a start request, ReadyOut_SO high
// REQ   | requesting the current channel from every active bank not yet accepted
// DATA  | waiting for read-valid from every active bank
// STEP  | one-cycle accumulate strobe, then next channel or finish
// DONE  | all channels sequenced (or timed out), ValidOut_SO until ReadyIn_SI
module spatial_sram_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int N_MOD1  = 32,
  parameter int N_MOD2  = 109,
  parameter int N_MOD3  = 214,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk_CI,
  input  logic              Reset_RBI,
  input  logic              ValidIn_SI,
  output logic              ReadyOut_SO,
  output logic              ValidOut_SO,
  input  logic              ReadyIn_SI,
  output logic [8:0]        SramReq_SO,
  input  logic [8:0]        SramReady_SI,
  input  logic [8:0]        SramValid_SI,
  output logic [ADDR_W-1:0] SramAddr_DO,
  output logic [2:0]        AccumEn_SO,
  output logic              First_SO,
  output logic [2:0]        LastMod_SO,
  output logic              Error_SO
);

  localparam int N_MAX_12 = (N_MOD1 > N_MOD2) ? N_MOD1 : N_MOD2;
  localparam int N_MAX    = (N_MAX_12 > N_MOD3) ? N_MAX_12 : N_MOD3;
  localparam int AW1      = ADDR_W + 1;
  localparam int TW       = $clog2(TIMEOUT + 1);

  // Channel counts widened by one bit so a count of 2**ADDR_W still compares.
  localparam logic [AW1-1:0]    N1_W     = AW1'(N_MOD1);
  localparam logic [AW1-1:0]    N2_W     = AW1'(N_MOD2);
  localparam logic [AW1-1:0]    N3_W     = AW1'(N_MOD3);
  localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(N_MAX - 1);
  // Down-counter reaches zero on the TIMEOUT-th cycle spent in REQ+DATA.
  localparam logic [TW-1:0]     TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    DATA = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cntr_q, cntr_d;
  logic [8:0]          acc_q, acc_d;
  logic [8:0]          dat_q, dat_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                err_q, err_d;

  logic [AW1-1:0]      cntr_ext;
  logic [2:0]          act;
  logic [2:0]          last_ch;
  logic [8:0]          bank_mask;
  logic [8:0]          acc_next;
  logic [8:0]          dat_next;
  logic                timer_tc;
  logic [TW-1:0]       timer_dec;

  // Channel masks, sticky accept/valid candidates and saturating timer step.
  always_comb begin
    cntr_ext   = {1'b0, cntr_q};
    act[0]     = cntr_ext < N1_W;
    act[1]     = cntr_ext < N2_W;
    act[2]     = cntr_ext < N3_W;
    last_ch[0] = cntr_ext == (N1_W - AW1'(1));
    last_ch[1] = cntr_ext == (N2_W - AW1'(1));
    last_ch[2] = cntr_ext == (N3_W - AW1'(1));
    bank_mask  = {{3{act[2]}}, {3{act[1]}}, {3{act[0]}}};
    acc_next   = acc_q | (SramReady_SI & bank_mask & ~acc_q);
    dat_next   = dat_q | (SramValid_SI & bank_mask);
    timer_tc   = (timer_q == '0);
    timer_dec  = timer_tc ? timer_q : timer_q - TW'(1);
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    cntr_d      = cntr_q;
    acc_d       = acc_q;
    dat_d       = dat_q;
    timer_d     = timer_q;
    err_d       = err_q;
    ReadyOut_SO = 1'b0;
    ValidOut_SO = 1'b0;
    SramReq_SO  = '0;
    AccumEn_SO  = '0;
    First_SO    = 1'b0;
    LastMod_SO  = '0;
    unique case (state_q)
      IDLE: begin
        ReadyOut_SO = 1'b1;
        if (ValidIn_SI) begin
          state_d = REQ;
          cntr_d  = '0;
          acc_d   = '0;
          dat_d   = '0;
          timer_d = TMO_LOAD;
        end
      end
      REQ: begin
        SramReq_SO = bank_mask & ~acc_q;
        acc_d      = acc_next;
        dat_d      = dat_next;
        timer_d    = timer_dec;
        // A channel still in REQ on its last allowed cycle cannot finish in time.
        if (timer_tc) begin
          state_d = DONE;
          err_d   = 1'b1;
          cntr_d  = '0;
        end else if (acc_next == bank_mask) begin
          state_d = DATA;
        end
      end
      DATA: begin
        dat_d   = dat_next;
        timer_d = timer_dec;
        if (dat_next == bank_mask) begin
          state_d = STEP;
        end else if (timer_tc) begin
          state_d = DONE;
          err_d   = 1'b1;
          cntr_d  = '0;
        end
      end
      STEP: begin
        AccumEn_SO = act;
        First_SO   = (cntr_q == '0);
        LastMod_SO = act & last_ch;
        if (cntr_q == LAST_CH) begin
          state_d = DONE;
          cntr_d  = '0;
        end else begin
          state_d = REQ;
          cntr_d  = cntr_q + ADDR_W'(1);
          acc_d   = '0;
          dat_d   = '0;
          timer_d = TMO_LOAD;
        end
      end
      DONE: begin
        ValidOut_SO = 1'b1;
        if (ReadyIn_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      state_q <= IDLE;
      cntr_q  <= '0;
      acc_q   <= '0;
      dat_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      acc_q   <= acc_d;
      dat_q   <= dat_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign SramAddr_DO = cntr_q;
  assign Error_SO    = err_q;

endmodule
